// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO and the
// UART byte buffers that instantiate it.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width; a one-entry array would still need a one-bit address.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Kept separate so it can later move to block RAM.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; resetting it would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// flush, sticky error flags and registered or first-word-fall-through reads.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int FWFT      = FIFO_MODE_REG,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    input  logic                        flush,
    input  logic                        clear_err,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [ptr_width(DEPTH):0]   count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_MARGIN >= DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_param: AF_MARGIN must be less than DEPTH");
    end
    if (AE_MARGIN >= DEPTH) begin : g_bad_ae
        $fatal(1, "sync_fifo_param: AE_MARGIN must be less than DEPTH");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] ram_rdata;
    logic             push_acc;
    logic             pop_acc;

    // Flush overrides both requests, so it is folded into acceptance here.
    assign push_acc = push && !full  && !flush;
    assign pop_acc  = pop  && !empty && !flush;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (push_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_acc, pop_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !flush) overflow <= 1'b1;
            else if (clear_err)         overflow <= 1'b0;

            if (pop && empty && !flush) underflow <= 1'b1;
            else if (clear_err)         underflow <= 1'b0;
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(DEPTH - AF_MARGIN));
    assign almost_empty = (count <= CW'(AE_MARGIN));

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign pop_data = ram_rdata;
    end else begin : g_reg
        logic [WIDTH-1:0] pop_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                pop_q <= '0;
            end else if (pop_acc) begin
                pop_q <= ram_rdata;
            end
        end

        assign pop_data = pop_q;
    end

endmodule
